// File: rtl/fir_decim_fifo.sv
// Decimator plus first-word-fall-through FIFO for the FIR output stream, with a sticky overflow flag.
// Define FIR_DECIM_AVG_EN to push a boxcar average of each group instead of its first sample.
module fir_decim_fifo #(
  parameter int DWIDTH = 16,
  parameter int DECIM  = 4,
  parameter int DEPTH  = 8
) (
  input  logic                       clk,
  input  logic                       arst,
  input  logic                       in_valid,
  input  logic signed [DWIDTH-1:0]   in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic signed [DWIDTH-1:0]   out_data,
  output logic [$clog2(DEPTH):0]     fill_level,
  output logic                       overflow,
  input  logic                       ovf_clear
);

  localparam int SH = (DECIM > 1) ? $clog2(DECIM) : 0;
  localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [PW-1:0]              phase_r;
  logic [AW-1:0]              wr_ptr_r;
  logic [AW-1:0]              rd_ptr_r;
  logic [CW-1:0]              count_r;
  logic                       overflow_r;
  logic signed [DWIDTH-1:0]   mem_r [DEPTH];

  logic                       keep_s;
  logic signed [DWIDTH-1:0]   push_data_s;
  logic                       pop_s;
  logic                       push_ok_s;
  logic                       drop_s;

`ifdef FIR_DECIM_AVG_EN
  localparam int ACCW = DWIDTH + SH;
  logic signed [ACCW-1:0] acc_r;
  logic signed [ACCW-1:0] sum_s;
  logic signed [ACCW-1:0] avg_s;

  // Group sum including the current sample; arithmetic shift floors toward minus infinity.
  always_comb begin
    sum_s       = acc_r + ACCW'(in_data);
    avg_s       = sum_s >>> SH;
    push_data_s = avg_s[DWIDTH-1:0];
    if (in_valid && (phase_r == PW'(DECIM - 1))) begin
      keep_s = 1'b1;
    end else begin
      keep_s = 1'b0;
    end
  end

  // Accumulator restarts on the first sample of each group.
  always_ff @(posedge clk) begin
    if (arst) begin
      acc_r <= '0;
    end else if (in_valid) begin
      if (phase_r == PW'(0)) begin
        acc_r <= ACCW'(in_data);
      end else begin
        acc_r <= sum_s;
      end
    end
  end
`else
  // Keep only the first sample of each decimation group.
  always_comb begin
    push_data_s = in_data;
    if (in_valid && (phase_r == PW'(0))) begin
      keep_s = 1'b1;
    end else begin
      keep_s = 1'b0;
    end
  end
`endif

  // Handshake decode: a full FIFO still accepts a push when the head leaves in the same cycle.
  always_comb begin
    pop_s = (count_r != CW'(0)) && out_ready;
    if (keep_s && ((count_r < CW'(DEPTH)) || pop_s)) begin
      push_ok_s = 1'b1;
    end else begin
      push_ok_s = 1'b0;
    end
    drop_s = keep_s && !push_ok_s;
  end

  // Phase counter advances on accepted input samples only.
  always_ff @(posedge clk) begin
    if (arst) begin
      phase_r <= '0;
    end else if (in_valid) begin
      if (phase_r == PW'(DECIM - 1)) begin
        phase_r <= '0;
      end else begin
        phase_r <= phase_r + PW'(1);
      end
    end
  end

  // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of 2.
  always_ff @(posedge clk) begin
    if (arst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_ok_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Sample storage; contents are unobservable while empty, so no reset.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= push_data_s;
    end
  end

  // Sticky overflow: a new drop beats a simultaneous clear.
  always_ff @(posedge clk) begin
    if (arst) begin
      overflow_r <= 1'b0;
    end else if (drop_s) begin
      overflow_r <= 1'b1;
    end else if (ovf_clear) begin
      overflow_r <= 1'b0;
    end else begin
      overflow_r <= overflow_r;
    end
  end

  // Head-of-FIFO presentation, forced to zero while empty.
  always_comb begin
    if (count_r != CW'(0)) begin
      out_data = mem_r[rd_ptr_r];
    end else begin
      out_data = '0;
    end
  end

  assign out_valid  = (count_r != CW'(0));
  assign fill_level = count_r;
  assign overflow   = overflow_r;

endmodule

// File: tb/tb_fir_decim_fifo.sv
// Directed, table-driven bench for fir_decim_fifo (DWIDTH=16, DECIM=4, DEPTH=8).
module tb_fir_decim_fifo;

  logic               clk = 1'b0;
  logic               arst = 1'b1;
  logic               in_valid = 1'b0;
  logic signed [15:0] in_data = 16'sd0;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic signed [15:0] out_data;
  logic [3:0]         fill_level;
  logic               overflow;
  logic               ovf_clear = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  fir_decim_fifo #(.DWIDTH(16), .DECIM(4), .DEPTH(8)) dut (
    .clk(clk), .arst(arst), .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .fill_level(fill_level), .overflow(overflow), .ovf_clear(ovf_clear)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic [15:0] id;
    logic        ordy;
    logic        ev;
    logic [15:0] ed;
    logic [3:0]  ef;
    logic        eo;
  } vec_t;

  vec_t tbl[16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    arst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; ovf_clear = 1'b0;
    tick();
    arst = 1'b0;
  endtask

  logic [15:0] drain_exp[8];

  initial begin
    // Streaming with out_ready=1: each kept sample appears for exactly one cycle.
    for (int i = 0; i < 16; i++) begin
      tbl[i].iv   = 1'b1;
      tbl[i].id   = 16'(i);
      tbl[i].ordy = 1'b1;
      tbl[i].ev   = ((i % 4) == 0);
      tbl[i].ed   = ((i % 4) == 0) ? 16'(i) : 16'd0;
      tbl[i].ef   = ((i % 4) == 0) ? 4'd1 : 4'd0;
      tbl[i].eo   = 1'b0;
    end

    // Reset then idle
    do_reset();
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_valid", 32'(out_valid), 32'd0);
      chk("idle_data",  32'(out_data),  32'd0);
      chk("idle_fill",  32'(fill_level), 32'd0);
      chk("idle_ovf",   32'(overflow),  32'd0);
    end

    // Table-driven streaming
    for (int i = 0; i < 16; i++) begin
      in_valid = tbl[i].iv; in_data = tbl[i].id; out_ready = tbl[i].ordy;
      tick();
      chk("stream_valid", 32'(out_valid),  32'(tbl[i].ev));
      chk("stream_data",  32'(out_data),   32'(tbl[i].ed));
      chk("stream_fill",  32'(fill_level), 32'(tbl[i].ef));
      chk("stream_ovf",   32'(overflow),   32'(tbl[i].eo));
    end
    in_valid = 1'b0;
    tick();

    // Fill with back-pressure, overflow on the first lost sample
    do_reset();
    for (int i = 0; i < 40; i++) begin
      in_valid = 1'b1; in_data = 16'(i); out_ready = 1'b0;
      tick();
      if (i == 28) begin
        chk("fill_at28", 32'(fill_level), 32'd8);
        chk("ovf_at28",  32'(overflow),   32'd0);
      end
      if (i == 31) chk("ovf_at31", 32'(overflow), 32'd0);
      if (i == 32) begin
        chk("ovf_at32",  32'(overflow),   32'd1);
        chk("fill_at32", 32'(fill_level), 32'd8);
      end
    end
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_data",  32'(out_data),  32'd0);
      chk("stall_valid", 32'(out_valid), 32'd1);
    end
    ovf_clear = 1'b1;
    tick();
    ovf_clear = 1'b0;
    chk("ovf_cleared", 32'(overflow), 32'd0);

    // Full FIFO, push and pop together
    in_valid = 1'b1; in_data = 16'd100; out_ready = 1'b1;
    tick();
    chk("pp_fill", 32'(fill_level), 32'd8);
    chk("pp_ovf",  32'(overflow),   32'd0);
    chk("pp_head", 32'(out_data),   32'd4);

    // Drop coinciding with ovf_clear: set wins
    out_ready = 1'b0;
    for (int i = 101; i <= 103; i++) begin
      in_data = 16'(i);
      tick();
    end
    chk("ovf_unkept", 32'(overflow), 32'd0);
    in_data = 16'd104; ovf_clear = 1'b1;
    tick();
    chk("ovf_setwins", 32'(overflow),   32'd1);
    chk("ovf_sw_fill", 32'(fill_level), 32'd8);

    // Drain in order
    in_valid = 1'b0; ovf_clear = 1'b0; out_ready = 1'b1;
    drain_exp = '{16'd4, 16'd8, 16'd12, 16'd16, 16'd20, 16'd24, 16'd28, 16'd100};
    for (int k = 0; k < 8; k++) begin
      chk("drain_data",  32'(out_data),  32'(drain_exp[k]));
      chk("drain_valid", 32'(out_valid), 32'd1);
      tick();
    end
    chk("drained_valid", 32'(out_valid),  32'd0);
    chk("drained_fill",  32'(fill_level), 32'd0);
    chk("drained_data",  32'(out_data),   32'd0);
    chk("drained_ovf",   32'(overflow),   32'd1);

    // Reset mid-group with 3 samples stored
    do_reset();
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_data = 16'(i); out_ready = 1'b0;
      tick();
    end
    chk("pre_rst_fill", 32'(fill_level), 32'd3);
    in_valid = 1'b0; arst = 1'b1;
    tick();
    arst = 1'b0;
    chk("rst_fill",  32'(fill_level), 32'd0);
    chk("rst_valid", 32'(out_valid),  32'd0);
    chk("rst_data",  32'(out_data),   32'd0);
    in_valid = 1'b1; in_data = 16'd55;
    tick();
    in_valid = 1'b0;
    chk("post_rst_valid", 32'(out_valid),  32'd1);
    chk("post_rst_data",  32'(out_data),   32'd55);
    chk("post_rst_fill",  32'(fill_level), 32'd1);

`ifdef FIR_DECIM_AVG_EN
    begin
      logic [15:0] grp[3][4];
      logic [15:0] avg_exp[3];
      grp = '{'{16'd1, 16'd2, 16'd3, 16'd4},
              '{16'hFFFF, 16'hFFFE, 16'hFFFE, 16'hFFFE},
              '{16'd32767, 16'd32767, 16'd32767, 16'd32767}};
      avg_exp = '{16'd2, 16'hFFFE, 16'd32767};
      do_reset();
      out_ready = 1'b1;
      for (int g = 0; g < 3; g++) begin
        for (int s = 0; s < 4; s++) begin
          in_valid = 1'b1; in_data = grp[g][s];
          tick();
        end
        chk("avg_valid", 32'(out_valid), 32'd1);
        chk("avg_data",  32'(out_data),  32'(avg_exp[g]));
      end
      in_valid = 1'b0;
      tick();
      chk("avg_empty", 32'(out_valid), 32'd0);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fir_decim_fifo.md
Name: fir_decim_fifo

Overview:
- Downstream consumer of the parallel FIR filter's output stream (valid + signed sample).
- Decimates the filtered stream by DECIM and buffers the kept samples in a small first-word-fall-through FIFO.
- Presents kept samples to the next stage over a valid/ready handshake.
- Flags samples lost to back-pressure with a sticky overflow bit.

Parameters:
- DWIDTH, 16, sample width; matches the FIR output width.
- DECIM, 4, decimation factor; legal range 1..256; must be a power of 2 when FIR_DECIM_AVG_EN is defined.
- DEPTH, 8, FIFO depth in samples; power of 2, at least 2.

Ports:
- clk  input  1  clock.
- arst  input  1  reset; synchronous, active-high.
- in_valid  input  1  input sample strobe (connects to FIR output_valid).
- in_data  input  DWIDTH  signed input sample (connects to FIR dout).
- out_valid  output  1  FIFO non-empty; out_data is valid.
- out_ready  input  1  downstream accepts the sample when high together with out_valid.
- out_data  output  DWIDTH  signed head-of-FIFO sample.
- fill_level  output  $clog2(DEPTH)+1  number of samples stored.
- overflow  output  1  sticky flag; a kept sample was dropped.
- ovf_clear  input  1  clears overflow.

Behaviour:
- Reset: arst sampled on the rising edge of clk, as already decided (reset arst, synchronous, active-high; clock clk).
  - Clears phase counter, read/write pointers, fill count, overflow and accumulator.
  - Outputs after reset: out_valid=0, out_data=0, fill_level=0, overflow=0.
  - Reset mid-operation discards all stored samples and any partial decimation group.
- Phase counter (0..DECIM-1):
  - Advances by 1 on every cycle with in_valid=1 and wraps from DECIM-1 to 0.
  - Holds when in_valid=0.
- Keep rule (default build): the sample accepted while phase==0 is kept; the rest of the group is discarded. DECIM=1 keeps every sample.
- Push:
  - A kept sample is written at write pointer and the pointer increments modulo DEPTH.
  - Written only if count<DEPTH, or if a pop occurs in the same cycle.
- Full case: otherwise the sample is dropped, overflow is set, and pointers and count are unchanged.
- Pop: occurs when out_valid && out_ready; the read pointer increments modulo DEPTH.
- Count:
  - Push only: +1. Pop only: -1. Push and pop together: unchanged.
  - fill_level equals the registered count.
- Output side:
  - out_valid = (count!=0).
  - out_data = mem[rd_ptr] when non-empty, else 0. It holds stable while out_valid && !out_ready.
- Latency: a sample kept on edge N is visible on out_data/out_valid after edge N, i.e. one cycle from in_valid to out_valid.
- Empty FIFO with simultaneous push: no bypass. out_valid rises the cycle after the push; out_ready on an empty FIFO has no effect.
- Overflow: when ovf_clear and a new drop occur in the same cycle, set wins. overflow otherwise holds until ovf_clear.
- Arithmetic: no width change in the default build; samples pass bit-exact.

Optional Feature:
- Macro: FIR_DECIM_AVG_EN.
- Defined (boxcar average):
  - An accumulator of DWIDTH+$clog2(DECIM) bits sums every sample of a group. It loads in_data at phase 0 and adds at the other phases.
  - On the sample accepted at phase DECIM-1, the value (acc+in_data) is arithmetically shifted right by $clog2(DECIM), truncating toward minus infinity, and pushed under the same full/overflow rules.
  - Latency: one cycle after the last sample of the group.
  - Reset mid-group discards the partial sum.
- Undefined: the keep-first rule above applies, and no accumulator is synthesized.

Test Plan:
- Reset then idle: out_valid=0, out_data=0, fill_level=0, overflow=0 for 10 cycles.
- DECIM=4, out_ready=1, in_valid=1 continuous with in_data=0,1,2,...,15 → outputs 0,4,8,12, each out_valid pulse one cycle after its input cycle; fill_level never exceeds 1.
- DECIM=4, DEPTH=8, out_ready=0, 40 consecutive samples → 8 samples stored (0,4,...,28), fill_level=8; the sample 32 drop sets overflow; draining yields 0..28 in order and out_data is stable while stalled.
- Full FIFO with out_ready=1 on the same cycle a kept sample arrives → push accepted, no overflow, fill_level stays 8. Separately, ovf_clear asserted with a simultaneous drop → overflow remains 1.
- arst asserted mid-group with 3 samples stored → next cycle fill_level=0, out_valid=0, and phase restarts (the next in_valid sample is kept).
- With FIR_DECIM_AVG_EN, DECIM=4: inputs 1,2,3,4 → output 2; inputs -1,-2,-2,-2 → output -2 (floor of -7/4); inputs 32767 ×4 → output 32767 with no wrap.
